conv_window_buffer: RTL and testbench

Sliding-window generator directly upstream of the convolution unit. It accepts a raster-order stream of DATA_WIDTH-bit pixels for one H×W single-channel feature map. For every stride-1 valid position, it presents the F×F patch as one flattened bus in the element order the convolution unit consumes, with a valid/ready handshake that stalls the pixel stream while a patch is pending.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/line_buffer.sv | 23 ++
 rtl/conv_window_buffer.sv | 110 +++++++++++
 tb/tb_conv_window_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared geometry and derived widths for the convolution front end.
// Every block in the window path imports this package instead of taking parameters.
package cnn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int F          = 5;
  localparam int W          = 28;
  localparam int H          = 28;

  localparam int COL_W  = $clog2(W);
  localparam int ROW_W  = $clog2(H);
  localparam int WCOL_W = $clog2(W - F + 1);
  localparam int WROW_W = $clog2(H - F + 1);
  localparam int WIN_W  = F * F * DATA_WIDTH;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage.
// Reads are combinational and writes are registered, sharing a single address.
module line_buffer
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [COL_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [W];

  // Contents are deliberately not reset.
  // Partial windows are never emitted, so stale entries cannot reach the output.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-stream to F x F sliding-window generator with a valid/ready output.
// The pixel stream stalls while a captured patch has not been consumed.
module conv_window_buffer
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic [WIN_W-1:0]      window,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic [WROW_W-1:0]     window_row,
  output logic [WCOL_W-1:0]     window_col,
  output logic                  frame_done
);

  logic                  accept;
  logic                  capture;
  logic                  last_col;
  logic                  last_pix;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] lb_rd   [F-1];
  logic [DATA_WIDTH-1:0] sw      [F][F];
  logic [DATA_WIDTH-1:0] sw_next [F][F];
  logic [WIN_W-1:0]      sw_flat;

  assign pixel_ready = !window_valid || window_ready;
  assign accept      = pixel_valid && pixel_ready;
  assign last_col    = (col == COL_W'(W - 1));
  assign last_pix    = last_col && (row == ROW_W'(H - 1));
  assign capture     = accept && (row >= ROW_W'(F - 1)) && (col >= COL_W'(F - 1));

  // Buffer k holds the row k+1 above the current one.
  // On each accept, the column cascades one buffer further up.
  for (genvar k = 0; k < F - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      line_buffer u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (pixel_in),
        .rdata (lb_rd[k])
      );
    end else begin : g_rest
      line_buffer u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb_rd[k-1]),
        .rdata (lb_rd[k])
      );
    end
  end

  always_comb begin
    sw_next = sw;
    sw_flat = '0;
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F - 1; c++) begin
        sw_next[r][c] = sw[r][c+1];
      end
    end
    // Oldest row sits at the top of the new right-hand column.
    for (int r = 0; r < F - 1; r++) begin
      sw_next[r][F-1] = lb_rd[F-2-r];
    end
    sw_next[F-1][F-1] = pixel_in;
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        sw_flat[DATA_WIDTH*(r*F+c) +: DATA_WIDTH] = sw_next[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      sw           <= '{default: '0};
      window       <= '0;
      window_valid <= 1'b0;
      window_row   <= '0;
      window_col   <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;
      if (accept) begin
        sw <= sw_next;
        if (last_col) begin
          col <= '0;
          row <= last_pix ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (capture) begin
        window       <= sw_flat;
        window_valid <= 1'b1;
        window_row   <= WROW_W'(row - ROW_W'(F - 1));
        window_col   <= WCOL_W'(col - COL_W'(F - 1));
      end else if (window_ready) begin
        window_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomized bench for conv_window_buffer, checked against an image-array model.
// Expected patches are cut directly out of the frame accepted so far.
module tb_conv_window_buffer;
  import cnn_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [WIN_W-1:0]      window;
  logic                  window_valid;
  logic                  window_ready;
  logic [WROW_W-1:0]     window_row;
  logic [WCOL_W-1:0]     window_col;
  logic                  frame_done;

  conv_window_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window       (window),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .window_row   (window_row),
    .window_col   (window_col),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIN_W-1:0] win;
    int               row;
    int               col;
    int               acc;
  } exp_t;

  int vectors     = 0;
  int miscompares = 0;

  exp_t                  q[$];
  logic [DATA_WIDTH-1:0] img [H][W];
  int  mr = 0, mc = 0, acc_cnt = 0, win_in_frame = 0, fd_count = 0;
  bit  fd_exp = 0, have_prev = 0, held = 0;
  int  prev_row = 0, prev_col = 0;
  logic [WIN_W-1:0]  held_win;
  logic [WROW_W-1:0] held_row;
  logic [WCOL_W-1:0] held_col;
  int  bp_cnt   = 0;
  int  cur_base = 0;
  bit  cur_ramp = 1;

  function automatic void chk(string nm, logic [WIN_W-1:0] got, logic [WIN_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Single compare process: every cycle, checked on the falling edge.
  always @(negedge clk) begin
    exp_t             e;
    exp_t             n;
    logic [WIN_W-1:0] lit;
    int               er, ec;
    if (reset) begin
      q.delete();
      mr = 0; mc = 0; acc_cnt = 0; win_in_frame = 0;
      fd_exp = 0; have_prev = 0; held = 0;
      chk("valid_in_reset", WIN_W'(window_valid), '0);
    end else begin
      chk("pixel_ready", WIN_W'(pixel_ready), WIN_W'(!window_valid || window_ready));
      chk("window_valid", WIN_W'(window_valid), WIN_W'(q.size() != 0));
      chk("frame_done", WIN_W'(frame_done), WIN_W'(fd_exp));
      if (frame_done) fd_count++;
      if (held) begin
        chk("stable_window", window, held_win);
        chk("stable_row", WIN_W'(window_row), WIN_W'(held_row));
        chk("stable_col", WIN_W'(window_col), WIN_W'(held_col));
      end
      held     = window_valid && !window_ready;
      held_win = window;
      held_row = window_row;
      held_col = window_col;

      if (window_valid && window_ready && q.size() > 0) begin
        e = q.pop_front();
        win_in_frame++;
        chk("window", window, e.win);
        chk("window_row", WIN_W'(window_row), WIN_W'(e.row));
        chk("window_col", WIN_W'(window_col), WIN_W'(e.col));
        if (have_prev) begin
          er = prev_row; ec = prev_col + 1;
          if (ec > W - F) begin ec = 0; er = er + 1; end
          if (er > H - F) er = 0;
          chk("seq_row", WIN_W'(e.row), WIN_W'(er));
          chk("seq_col", WIN_W'(e.col), WIN_W'(ec));
        end
        have_prev = 1; prev_row = e.row; prev_col = e.col;
        if (e.row == 0 && e.col == 0) begin
          chk("first_window_accepts", WIN_W'(e.acc), WIN_W'(117));
          if (cur_ramp) begin
            lit = '0;
            for (int i = 0; i < F * F; i++)
              lit[DATA_WIDTH*i +: DATA_WIDTH] = DATA_WIDTH'(cur_base + (i / F) * W + i % F);
            chk("first_window_literal", window, lit);
          end
        end
        if (e.row == H - F && e.col == W - F) begin
          chk("windows_per_frame", WIN_W'(win_in_frame), WIN_W'(576));
          win_in_frame = 0;
        end
      end

      fd_exp = 0;
      if (pixel_valid && pixel_ready) begin
        img[mr][mc] = pixel_in;
        acc_cnt++;
        if (mr >= F - 1 && mc >= F - 1) begin
          for (int i = 0; i < F * F; i++)
            n.win[DATA_WIDTH*i +: DATA_WIDTH] = img[mr-(F-1)+i/F][mc-(F-1)+i%F];
          n.row = mr - (F - 1);
          n.col = mc - (F - 1);
          n.acc = acc_cnt;
          q.push_back(n);
        end
        if (mr == H - 1 && mc == W - 1) begin
          fd_exp  = 1;
          acc_cnt = 0;
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
    end
  end

  task automatic run_frame(input int base, input bit rnd_pix, input int vpct,
                           input bit rrand, input int n_acc);
    int r = 0, c = 0, acc = 0, cyc = 0;
    bit accepted;
    cur_base = base;
    cur_ramp = !rnd_pix;
    while (acc < n_acc) begin
      pixel_valid = ($urandom_range(99) < vpct);
      pixel_in    = rnd_pix ? DATA_WIDTH'($urandom) : DATA_WIDTH'(base + r * W + c);
      if (bp_cnt > 0 && window_valid) begin
        window_ready = 1'b0;
        bp_cnt--;
      end else begin
        window_ready = rrand ? 1'($urandom_range(1)) : 1'b1;
      end
      @(negedge clk);
      accepted = pixel_valid && pixel_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        acc++;
        c++;
        if (c == W) begin c = 0; r++; end
      end
      cyc++;
      if (cyc > 20000) begin
        chk("frame_cycle_budget", WIN_W'(acc), WIN_W'(n_acc));
        break;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    pixel_valid  = 1'b0;
    pixel_in     = '0;
    window_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_window", window, '0);
    chk("reset_row", WIN_W'(window_row), '0);
    chk("reset_col", WIN_W'(window_col), '0);
    chk("reset_frame_done", WIN_W'(frame_done), '0);
    chk("reset_pixel_ready", WIN_W'(pixel_ready), WIN_W'(1));
    reset = 1'b0;

    bp_cnt = 10;
    run_frame(0, 0, 100, 0, H * W);
    run_frame(1000, 0, 100, 0, H * W);
    run_frame(0, 1, 50, 1, H * W);
    run_frame(3000, 0, 100, 0, 300);

    reset = 1'b1;
    #1;
    chk("abort_valid", WIN_W'(window_valid), '0);
    chk("abort_row", WIN_W'(window_row), '0);
    chk("abort_window", window, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_frame(2000, 0, 100, 0, H * W);
    pixel_valid  = 1'b0;
    window_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", WIN_W'(q.size()), '0);
    chk("frame_done_count", WIN_W'(fd_count), WIN_W'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
